// File: rtl/iir_fold_pkg.sv
// Shared types, widths and result helper for the folding_2 IIR family.
// The saturate/truncate helper is width-generic (up to MAX_W data bits) so
// every revision of the fold datapath can share it.
package iir_fold_pkg;

  // Default data/coefficient width.
  localparam int DATA_W    = 16;
  // Accumulator width: full 2n-bit product plus two guard bits.
  localparam int ACC_W     = 2 * DATA_W + 2;
  // Widest data path the shared helper supports.
  localparam int MAX_W     = 32;
  localparam int MAX_ACC_W = 2 * MAX_W + 2;

  // Two-phase fold: LOAD accepts a sample, MAC finishes it.
  typedef enum logic {
    LOAD = 1'b0,
    MAC  = 1'b1
  } fold_state_e;

  // Reduces a sign-extended accumulator to a w-bit result.
  // sat_en = 0: keep the low bits (wrap-around).
  // sat_en = 1: clamp to [-2^(w-1), 2^(w-1)-1] first.
  // The caller takes the low w bits of the returned value.
  function automatic logic signed [MAX_ACC_W-1:0] fold_result(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          w,
    input logic                        sat_en
  );
    logic signed [MAX_ACC_W-1:0] one;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    logic signed [MAX_ACC_W-1:0] r;
    one = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    r   = acc;
    if (sat_en) begin
      if (acc > hi) begin
        r = hi;
      end else if (acc < lo) begin
        r = lo;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fold_mac.sv
// Time-shared multiply-subtract for the folded inverse filter:
// res = acc_in - coef * hist, at full accumulator precision.
module fold_mac
  import iir_fold_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic signed [2*n+1:0] acc_in,
  input  logic signed [n-1:0]   coef,
  input  logic signed [n-1:0]   hist,
  output logic signed [2*n+1:0] res
);

  logic signed [2*n-1:0] prod;

  // Full-width signed product, sign-extended into the accumulator subtract.
  always_comb begin
    prod = coef * hist;
    res  = acc_in - (2*n+2)'(prod);
  end

endmodule

// File: rtl/iir_inverse_fold2.sv
// 2-folded inverse of the folding_2 IIR: X(n) = Y(n) - a*Y(n-1) - b*Y(n-2).
// One fold_mac is shared over two phases (LOAD, MAC): one sample per 2 clocks.
// Optional macro IIR_INV_SATURATE_EN: clamp the result instead of wrapping.
module iir_inverse_fold2
  import iir_fold_pkg::*;
#(
  parameter int n = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] Yn,
  input  logic         yn_valid,
  output logic         yn_ready,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] Xn,
  output logic         xn_valid
);

`ifdef IIR_INV_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam int ACC_W_L = 2 * n + 2;

  fold_state_e state_q, state_d;

  logic [n-1:0] y_cur_q, y_cur_d;
  logic [n-1:0] a_r_q,   a_r_d;
  logic [n-1:0] b_r_q,   b_r_d;
  logic [n-1:0] d1_q,    d1_d;
  logic [n-1:0] d2_q,    d2_d;
  logic [n-1:0] xn_q,    xn_d;
  logic         xn_valid_q, xn_valid_d;

  logic signed [ACC_W_L-1:0] acc_q, acc_d;

  logic signed [ACC_W_L-1:0] mac_acc_in;
  logic signed [n-1:0]       mac_coef;
  logic signed [n-1:0]       mac_hist;
  logic signed [ACC_W_L-1:0] mac_res;

  logic accept;

  // Ready only in LOAD and never while reset is held.
  assign yn_ready = (state_q == LOAD) && !rst;
  assign accept   = yn_valid && yn_ready;

  // Operand mux for the shared multiply-subtract: (Yn, a, d1) then (acc, b_r, d2).
  always_comb begin
    if (state_q == MAC) begin
      mac_acc_in = acc_q;
      mac_coef   = $signed(b_r_q);
      mac_hist   = $signed(d2_q);
    end else begin
      mac_acc_in = ACC_W_L'($signed(Yn));
      mac_coef   = $signed(a);
      mac_hist   = $signed(d1_q);
    end
  end

  fold_mac #(
    .n (n)
  ) u_mac (
    .acc_in (mac_acc_in),
    .coef   (mac_coef),
    .hist   (mac_hist),
    .res    (mac_res)
  );

  // Next-state and datapath updates for the two-phase fold.
  always_comb begin
    // NOTE: every *_d gets a hold value first, so no path through this block
    // leaves a variable unassigned and no latch can be inferred.
    state_d    = state_q;
    y_cur_d    = y_cur_q;
    a_r_d      = a_r_q;
    b_r_d      = b_r_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    acc_d      = acc_q;
    xn_d       = xn_q;
    xn_valid_d = 1'b0;

    unique case (state_q)
      LOAD: begin
        if (accept) begin
          y_cur_d = Yn;
          a_r_d   = a;
          b_r_d   = b;
          acc_d   = mac_res;
          state_d = MAC;
        end
      end
      MAC: begin
        xn_d       = n'(fold_result(MAX_ACC_W'(mac_res), n, SAT_EN));
        xn_valid_d = 1'b1;
        d2_d       = d1_q;
        d1_d       = y_cur_q;
        state_d    = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State register with synchronous active-high reset; reset drops any in-flight sample.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q    <= LOAD;
      y_cur_q    <= '0;
      a_r_q      <= '0;
      b_r_q      <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      acc_q      <= '0;
      xn_q       <= '0;
      xn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_cur_q    <= y_cur_d;
      a_r_q      <= a_r_d;
      b_r_q      <= b_r_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      acc_q      <= acc_d;
      xn_q       <= xn_d;
      xn_valid_q <= xn_valid_d;
    end
  end

  assign Xn       = xn_q;
  assign xn_valid = xn_valid_q;

endmodule

// File: tb/tb_iir_inverse_fold2.sv
// Self-checking bench for iir_inverse_fold2 (n = 16).
// Reference: accepted samples are inverted with plain integer arithmetic,
// X = Y - a*Y[-1] - b*Y[-2], result due one clock after the accept edge.
module tb_iir_inverse_fold2;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] yn;
  logic         yn_valid;
  logic         yn_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] xn;
  logic         xn_valid;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state.
  longint       hist1 = 0;
  longint       hist2 = 0;
  bit           pending = 1'b0;
  longint       p_y = 0;
  longint       p_a = 0;
  longint       p_b = 0;
  logic [N-1:0] exp_xn = '0;
  logic         exp_xv = 1'b0;
  bit           last_accept = 1'b0;

  logic [N-1:0] obs_q[$];

  always #5 clk = ~clk;

  iir_inverse_fold2 #(
    .n (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Yn       (yn),
    .yn_valid (yn_valid),
    .yn_ready (yn_ready),
    .a        (a),
    .b        (b),
    .Xn       (xn),
    .xn_valid (xn_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_x(input longint y, input longint ca, input longint cb,
                                           input longint p1, input longint p2);
    longint x;
    x = y - ca * p1 - cb * p2;
`ifdef IIR_INV_SATURATE_EN
    if (x > 32767) x = 32767;
    else if (x < -32768) x = -32768;
`endif
    return x[N-1:0];
  endfunction

  // One clock: drive inputs, check ready, advance, check outputs against the model.
  task automatic tick(input logic v, input logic [N-1:0] y);
    bit acc;
    yn_valid = v;
    yn       = y;
    #1;
    check("yn_ready", 32'(yn_ready), 32'(!pending && !rst));
    acc = v && !pending && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      hist1   = 0;
      hist2   = 0;
      pending = 1'b0;
      exp_xv  = 1'b0;
      exp_xn  = '0;
    end else begin
      exp_xv = 1'b0;
      if (pending) begin
        exp_xn  = model_x(p_y, p_a, p_b, hist1, hist2);
        exp_xv  = 1'b1;
        hist2   = hist1;
        hist1   = p_y;
        pending = 1'b0;
      end
      if (acc) begin
        pending = 1'b1;
        p_y     = longint'($signed(y));
        p_a     = longint'($signed(a));
        p_b     = longint'($signed(b));
      end
    end
    check("xn_valid", 32'(xn_valid), 32'(exp_xv));
    check("Xn", 32'(xn), 32'(exp_xn));
    if (xn_valid === 1'b1) obs_q.push_back(xn);
    last_accept = acc;
  endtask

  // Hold yn_valid until the sample is taken, with a bounded number of tries.
  task automatic send(input logic [N-1:0] y);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4 && !done; i++) begin
      tick(1'b1, y);
      done = last_accept;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] dir_y[4];
    logic [N-1:0] dir_x[4];
    logic [N-1:0] gap_y[4];
    logic [N-1:0] run1[$];
    int           pulses;
    logic [N-1:0] ovf_exp;

    rst      = 1'b1;
    yn_valid = 1'b0;
    yn       = '0;
    a        = '0;
    b        = '0;

    // Reset state.
    do_reset();
    check("reset_xn", 32'(xn), 32'd0);
    check("reset_xv", 32'(xn_valid), 32'd0);

    // Inverse check with a=2, b=3.
    dir_y = '{16'hFFFD, 16'hFFFF, 16'hFFF7, 16'hFFE9};   // -3, -1, -9, -23
    dir_x = '{16'hFFFD, 16'h0005, 16'h0002, 16'hFFFE};   // -3,  5,  2,  -2
    a = 16'd2;
    b = 16'd3;
    for (int i = 0; i < 4; i++) begin
      send(dir_y[i]);
      tick(1'b0, '0);
      check("dir_pulse", 32'(xn_valid), 32'd1);
      check("dir_xn", 32'(xn), 32'(dir_x[i]));
    end

    // Backpressure: valid held high, ready alternates, pulse every 2nd clock.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, N'($urandom));
      if (xn_valid === 1'b1) pulses++;
    end
    check("bp_pulses", 32'(pulses), 32'd4);
    tick(1'b0, '0);

    // Reset during MAC drops the sample and clears history.
    send(16'hFFFD);
    rst = 1'b1;
    tick(1'b0, '0);
    rst = 1'b0;
    check("rst_mid_xv", 32'(xn_valid), 32'd0);
    check("rst_mid_xn", 32'(xn), 32'd0);
    send(16'd7);
    tick(1'b0, '0);
    check("rst_clear_xn", 32'(xn), 32'd7);

    // Coefficients are latched at accept.
    do_reset();
    a = 16'd2;
    b = 16'd0;
    send(16'd10);
    tick(1'b0, '0);
    send(16'd20);
    a = 16'd5;
    tick(1'b0, '0);
    check("coef_hold_xn", 32'(xn), 32'd0);               // 20 - 2*10
    send(16'd1);
    tick(1'b0, '0);
    check("coef_next_xn", 32'(xn), 32'(16'hFF9D));       // 1 - 5*20 = -99

    // Overflow at the data range boundary.
    do_reset();
    a = 16'd1;
    b = 16'd0;
    send(16'h7FFF);
    tick(1'b0, '0);
    check("ovf_first_xn", 32'(xn), 32'h7FFF);
    send(16'h8000);
    tick(1'b0, '0);
`ifdef IIR_INV_SATURATE_EN
    ovf_exp = 16'h8000;
`else
    ovf_exp = 16'h0001;
`endif
    check("ovf_second_xn", 32'(xn), 32'(ovf_exp));

    // Idle gaps preserve history: compare gapped and gap-free runs.
    gap_y = '{16'd100, 16'hFF06, 16'd3000, 16'hFFF9};
    a = 16'hFFFD;
    b = 16'd7;
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(gap_y[i]);
      repeat (5) tick(1'b0, '0);
    end
    run1 = obs_q;
    do_reset();
    obs_q.delete();
    for (int i = 0; i < 4; i++) send(gap_y[i]);
    tick(1'b0, '0);
    check("gap_count", 32'(obs_q.size()), 32'(run1.size()));
    check("gap_count_abs", 32'(run1.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_q.size() && i < run1.size(); i++)
      check("gap_xn", 32'(run1[i]), 32'(obs_q[i]));

    // Randomized traffic with occasional resets and coefficient changes.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a   = N'($urandom);
      b   = N'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick($urandom_range(0, 9) < 7, N'($urandom));
    end
    rst = 1'b0;
    tick(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
